// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of the arbiter's stream inputs, the register file write port and the
// hazard-side status outputs. master = arbiter side, slave = environment side.
interface regfile_wb_arbiter_if #(
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic            pipe_valid;
  logic            pipe_ready;
  logic [4:0]      pipe_rd;
  logic [31:0]     pipe_data;
  logic            ext_valid;
  logic            ext_ready;
  logic [4:0]      ext_rd;
  logic [31:0]     ext_data;
  logic [4:0]      wsel;
  logic            wen;
  logic [31:0]     wdat;
  logic [31:0]     pend_mask;
  logic [CntW-1:0] fifo_cnt;

  modport master (
    input  pipe_valid, pipe_rd, pipe_data, ext_valid, ext_rd, ext_data,
    output pipe_ready, ext_ready, wsel, wen, wdat, pend_mask, fifo_cnt
  );

  modport slave (
    output pipe_valid, pipe_rd, pipe_data, ext_valid, ext_rd, ext_data,
    input  pipe_ready, ext_ready, wsel, wen, wdat, pend_mask, fifo_cnt
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register file writeback arbiter: merges the in-order pipe result stream and a
// FIFO-buffered multi-cycle (ext) result stream onto one registered write port.
// Pipe has priority; a starvation counter periodically forces one ext drain.
module regfile_wb_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input logic                  clk,
  input logic                  nrst,
  regfile_wb_arbiter_if.master bus
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned StW  = $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] CntFull   = CntW'(FIFO_DEPTH);
  localparam logic [StW-1:0]  StarveMax = StW'(STARVE_MAX);

  typedef enum logic [0:0] {StNormal, StForce} state_e;

  state_e          state_q;
  logic [StW-1:0]  starve_q;
  logic [StW-1:0]  starve_nxt;

  logic [4:0]            fifo_rd_q   [FIFO_DEPTH];
  logic [31:0]           fifo_data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_vld_q;
  logic [PtrW-1:0]       wr_ptr_q;
  logic [PtrW-1:0]       rd_ptr_q;
  logic [CntW-1:0]       cnt_q;

  logic        wen_q;
  logic [4:0]  wsel_q;
  logic [31:0] wdat_q;

  logic        fifo_empty;
  logic        ext_ready;
  logic        pipe_ready;
  logic        enq;
  logic        deq;
  logic        sel_pipe;
  logic [4:0]  sel_rd;
  logic [31:0] sel_data;
  logic [31:0] pend_mask;

  // Source selection: FORCE drains the FIFO head, NORMAL prefers pipe.
  always_comb begin
    fifo_empty = (cnt_q == '0);
    ext_ready  = (cnt_q != CntFull);
    pipe_ready = (state_q == StNormal);
    enq        = bus.ext_valid && ext_ready;
    sel_pipe   = 1'b0;
    deq        = 1'b0;
    if (state_q == StForce) begin
      deq = !fifo_empty;
    end else if (bus.pipe_valid) begin
      sel_pipe = 1'b1;
    end else if (!fifo_empty) begin
      deq = 1'b1;
    end
    sel_rd     = sel_pipe ? bus.pipe_rd   : fifo_rd_q[rd_ptr_q];
    sel_data   = sel_pipe ? bus.pipe_data : fifo_data_q[rd_ptr_q];
    starve_nxt = (starve_q == StarveMax) ? starve_q : starve_q + 1'b1;
  end

  // Pending-destination mask over all live FIFO entries; x0 never pends.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      if (fifo_vld_q[i]) pend_mask[fifo_rd_q[i]] = 1'b1;
    end
    pend_mask[0] = 1'b0;
  end

  // Ext FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_rd_q[i]   <= '0;
        fifo_data_q[i] <= '0;
      end
      fifo_vld_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      // enq and deq never hit the same slot: enq needs non-full, deq non-empty.
      if (deq) begin
        fifo_vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q             <= rd_ptr_q + 1'b1;
      end
      if (enq) begin
        fifo_rd_q[wr_ptr_q]   <= bus.ext_rd;
        fifo_data_q[wr_ptr_q] <= bus.ext_data;
        fifo_vld_q[wr_ptr_q]  <= 1'b1;
        wr_ptr_q              <= wr_ptr_q + 1'b1;
      end
      unique case ({enq, deq})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Arbitration FSM, starvation counter and registered write port.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= StNormal;
      starve_q <= '0;
      wen_q    <= 1'b0;
      wsel_q   <= '0;
      wdat_q   <= '0;
    end else begin
      wen_q <= 1'b0;
      // Writes to x0 complete the handshake but are dropped here.
      if ((sel_pipe || deq) && (sel_rd != 5'd0)) begin
        wen_q  <= 1'b1;
        wsel_q <= sel_rd;
        wdat_q <= sel_data;
      end
      unique case (state_q)
        StNormal: begin
          if (deq) begin
            starve_q <= '0;
          end else if (sel_pipe && !fifo_empty) begin
            starve_q <= starve_nxt;
            if (starve_nxt == StarveMax) state_q <= StForce;
          end
        end
        StForce: begin
          starve_q <= '0;
          state_q  <= StNormal;
        end
        default: state_q <= StNormal;
      endcase
    end
  end

  assign bus.pipe_ready = pipe_ready;
  assign bus.ext_ready  = ext_ready;
  assign bus.wen        = wen_q;
  assign bus.wsel       = wsel_q;
  assign bus.wdat       = wdat_q;
  assign bus.pend_mask  = pend_mask;
  assign bus.fifo_cnt   = cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (FIFO_DEPTH=4, STARVE_MAX=8).
module tb_regfile_wb_arbiter;

  logic clk;
  logic nrst;
  int   tests;
  int   fails;

  regfile_wb_arbiter_if #(.FIFO_DEPTH(4)) bus ();

  regfile_wb_arbiter #(.FIFO_DEPTH(4), .STARVE_MAX(8)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are observed 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    bus.pipe_valid = 1'b0; bus.pipe_rd = '0; bus.pipe_data = '0;
    bus.ext_valid  = 1'b0; bus.ext_rd  = '0; bus.ext_data  = '0;
    repeat (3) step();
    @(negedge clk);
    nrst = 1'b1;
    step();
    tests++; if (bus.wen !== 1'b0) begin fails++; $display("FAIL rst_wen: got %0h want 0", bus.wen); end
    tests++; if (bus.wsel !== 5'd0) begin fails++; $display("FAIL rst_wsel: got %0h want 0", bus.wsel); end
    tests++; if (bus.wdat !== 32'd0) begin fails++; $display("FAIL rst_wdat: got %0h want 0", bus.wdat); end
    tests++; if (bus.fifo_cnt !== 3'd0) begin fails++; $display("FAIL rst_cnt: got %0h want 0", bus.fifo_cnt); end
    tests++; if (bus.pend_mask !== 32'd0) begin fails++; $display("FAIL rst_pend: got %0h want 0", bus.pend_mask); end
    tests++; if (bus.ext_ready !== 1'b1) begin fails++; $display("FAIL rst_ext_rdy: got %0h want 1", bus.ext_ready); end
    tests++; if (bus.pipe_ready !== 1'b1) begin fails++; $display("FAIL rst_pipe_rdy: got %0h want 1", bus.pipe_ready); end
  endtask

  task automatic test_pipe_only();
    bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd5; bus.pipe_data = 32'hDEADBEEF;
    tests++; if (bus.pipe_ready !== 1'b1) begin fails++; $display("FAIL pipe_ready: got %0h want 1", bus.pipe_ready); end
    step();
    bus.pipe_valid = 1'b0;
    tests++; if (bus.wen !== 1'b1) begin fails++; $display("FAIL pipe_wen: got %0h want 1", bus.wen); end
    tests++; if (bus.wsel !== 5'd5) begin fails++; $display("FAIL pipe_wsel: got %0h want 5", bus.wsel); end
    tests++; if (bus.wdat !== 32'hDEADBEEF) begin fails++; $display("FAIL pipe_wdat: got %0h want deadbeef", bus.wdat); end
    step();
    tests++; if (bus.wen !== 1'b0) begin fails++; $display("FAIL pipe_idle_wen: got %0h want 0", bus.wen); end
    tests++; if (bus.wsel !== 5'd5) begin fails++; $display("FAIL pipe_hold_wsel: got %0h want 5", bus.wsel); end
  endtask

  task automatic test_ext_idle();
    bus.ext_valid = 1'b1; bus.ext_rd = 5'd7; bus.ext_data = 32'h12;
    tests++; if (bus.ext_ready !== 1'b1) begin fails++; $display("FAIL ext_ready: got %0h want 1", bus.ext_ready); end
    step();
    bus.ext_valid = 1'b0;
    tests++; if (bus.pend_mask !== 32'h80) begin fails++; $display("FAIL ext_pend1: got %0h want 80", bus.pend_mask); end
    tests++; if (bus.fifo_cnt !== 3'd1) begin fails++; $display("FAIL ext_cnt1: got %0h want 1", bus.fifo_cnt); end
    tests++; if (bus.wen !== 1'b0) begin fails++; $display("FAIL ext_wen1: got %0h want 0", bus.wen); end
    step();
    tests++; if (bus.wen !== 1'b1) begin fails++; $display("FAIL ext_wen2: got %0h want 1", bus.wen); end
    tests++; if (bus.wsel !== 5'd7) begin fails++; $display("FAIL ext_wsel2: got %0h want 7", bus.wsel); end
    tests++; if (bus.wdat !== 32'h12) begin fails++; $display("FAIL ext_wdat2: got %0h want 12", bus.wdat); end
    tests++; if (bus.pend_mask !== 32'h0) begin fails++; $display("FAIL ext_pend2: got %0h want 0", bus.pend_mask); end
    tests++; if (bus.fifo_cnt !== 3'd0) begin fails++; $display("FAIL ext_cnt2: got %0h want 0", bus.fifo_cnt); end
    step();
  endtask

  // Fill the FIFO behind a continuously valid pipe, then watch FORCE drain.
  task automatic test_full();
    int waited;
    bit seen;
    bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd1; bus.pipe_data = 32'h100;
    for (int i = 0; i < 4; i++) begin
      bus.ext_valid = 1'b1; bus.ext_rd = 5'(10 + i); bus.ext_data = 32'(i);
      tests++;
      if (bus.ext_ready !== 1'b1) begin
        fails++; $display("FAIL full_accept%0d: got %0h want 1", i, bus.ext_ready);
      end
      step();
    end
    bus.ext_valid = 1'b0;
    tests++; if (bus.ext_ready !== 1'b0) begin fails++; $display("FAIL full_ready: got %0h want 0", bus.ext_ready); end
    tests++; if (bus.fifo_cnt !== 3'd4) begin fails++; $display("FAIL full_cnt: got %0h want 4", bus.fifo_cnt); end
    tests++; if (bus.pend_mask !== 32'h3C00) begin fails++; $display("FAIL full_pend: got %0h want 3c00", bus.pend_mask); end
    waited = 0;
    seen = 1'b0;
    while (!seen && waited < 20) begin
      if (bus.pipe_ready === 1'b0) seen = 1'b1;
      else begin step(); waited++; end
    end
    tests++; if (waited !== 5) begin fails++; $display("FAIL full_force_at: got %0d want 5", waited); end
    step();
    tests++; if (bus.ext_ready !== 1'b1) begin fails++; $display("FAIL full_ready_after: got %0h want 1", bus.ext_ready); end
    tests++; if (bus.fifo_cnt !== 3'd3) begin fails++; $display("FAIL full_cnt_after: got %0h want 3", bus.fifo_cnt); end
    tests++; if (bus.pipe_ready !== 1'b1) begin fails++; $display("FAIL full_pipe_back: got %0h want 1", bus.pipe_ready); end
    tests++; if (bus.wsel !== 5'd10) begin fails++; $display("FAIL full_force_wsel: got %0h want a", bus.wsel); end
  endtask

  // Continues from test_full: 3 entries left, pipe still valid every cycle.
  task automatic test_starvation();
    logic [4:0] got [4];
    int n_ext;
    logic exp_ready;
    n_ext = 0;
    if (bus.wen === 1'b1 && bus.wsel >= 5'd10) begin got[0] = bus.wsel; n_ext = 1; end
    for (int s = 1; s <= 28; s++) begin
      exp_ready = (s % 9) != 0;
      tests++;
      if (bus.pipe_ready !== exp_ready) begin
        fails++; $display("FAIL starve_ready s=%0d: got %0h want %0h", s, bus.pipe_ready, exp_ready);
      end
      if (s > 1 && bus.wen === 1'b1 && bus.wsel >= 5'd10) begin
        if (n_ext < 4) got[n_ext] = bus.wsel;
        n_ext++;
      end
      step();
    end
    bus.pipe_valid = 1'b0;
    tests++; if (n_ext !== 4) begin fails++; $display("FAIL starve_nwrites: got %0d want 4", n_ext); end
    for (int i = 0; i < 4 && i < n_ext; i++) begin
      tests++;
      if (got[i] !== 5'(10 + i)) begin
        fails++; $display("FAIL starve_order%0d: got %0d want %0d", i, got[i], 10 + i);
      end
    end
    tests++; if (bus.fifo_cnt !== 3'd0) begin fails++; $display("FAIL starve_cnt: got %0h want 0", bus.fifo_cnt); end
    step();
  endtask

  task automatic test_x0();
    bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd0; bus.pipe_data = 32'hFFFFFFFF;
    tests++; if (bus.pipe_ready !== 1'b1) begin fails++; $display("FAIL x0_pipe_ready: got %0h want 1", bus.pipe_ready); end
    step();
    bus.pipe_valid = 1'b0;
    tests++; if (bus.wen !== 1'b0) begin fails++; $display("FAIL x0_pipe_wen: got %0h want 0", bus.wen); end
    tests++; if (bus.pend_mask[0] !== 1'b0) begin fails++; $display("FAIL x0_pend0: got %0h want 0", bus.pend_mask[0]); end
    bus.ext_valid = 1'b1; bus.ext_rd = 5'd0; bus.ext_data = 32'hFFFFFFFF;
    tests++; if (bus.ext_ready !== 1'b1) begin fails++; $display("FAIL x0_ext_ready: got %0h want 1", bus.ext_ready); end
    step();
    bus.ext_valid = 1'b0;
    tests++; if (bus.fifo_cnt !== 3'd1) begin fails++; $display("FAIL x0_ext_cnt: got %0h want 1", bus.fifo_cnt); end
    tests++; if (bus.pend_mask !== 32'd0) begin fails++; $display("FAIL x0_ext_pend: got %0h want 0", bus.pend_mask); end
    step();
    tests++; if (bus.wen !== 1'b0) begin fails++; $display("FAIL x0_ext_wen: got %0h want 0", bus.wen); end
    tests++; if (bus.fifo_cnt !== 3'd0) begin fails++; $display("FAIL x0_ext_drain: got %0h want 0", bus.fifo_cnt); end
    step();
    tests++; if (bus.wen !== 1'b0) begin fails++; $display("FAIL x0_ext_wen2: got %0h want 0", bus.wen); end
  endtask

  task automatic test_reset_mid();
    bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd2; bus.pipe_data = 32'h55;
    for (int i = 0; i < 3; i++) begin
      bus.ext_valid = 1'b1; bus.ext_rd = 5'(20 + i); bus.ext_data = 32'(i + 100);
      step();
    end
    bus.ext_valid = 1'b0;
    bus.pipe_valid = 1'b0;
    tests++; if (bus.fifo_cnt !== 3'd3) begin fails++; $display("FAIL rmid_pre_cnt: got %0h want 3", bus.fifo_cnt); end
    tests++; if (bus.wen !== 1'b1) begin fails++; $display("FAIL rmid_pre_wen: got %0h want 1", bus.wen); end
    #2;
    nrst = 1'b0;
    #1;
    tests++; if (bus.wen !== 1'b0) begin fails++; $display("FAIL rmid_wen: got %0h want 0", bus.wen); end
    tests++; if (bus.fifo_cnt !== 3'd0) begin fails++; $display("FAIL rmid_cnt: got %0h want 0", bus.fifo_cnt); end
    tests++; if (bus.pend_mask !== 32'd0) begin fails++; $display("FAIL rmid_pend: got %0h want 0", bus.pend_mask); end
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      tests++;
      if (bus.wen !== 1'b0) begin
        fails++; $display("FAIL rmid_stale%0d: got wen=%0h wsel=%0h want wen=0", i, bus.wen, bus.wsel);
      end
    end
    tests++; if (bus.fifo_cnt !== 3'd0) begin fails++; $display("FAIL rmid_post_cnt: got %0h want 0", bus.fifo_cnt); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_pipe_only();
    test_ext_idle();
    test_full();
    test_starvation();
    test_x0();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
